// File: rtl/trng_health_monitor.sv
// trng_health_monitor
// Bit-serial RCT/APT health tests on 32-bit TRNG words. A word that passes
// both tests goes into a first-word-fall-through output FIFO. A failure
// raises a sticky alarm and flushes the FIFO.
module trng_health_monitor #(
  parameter int RCT_CUTOFF = 32,
  parameter int APT_WINDOW = 1024,
  parameter int APT_CUTOFF = 589,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [31:0]                   in_data,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          alarm_clr,
  output logic                          alarm,
  output logic                          rct_fail,
  output logic                          apt_fail,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int RUN_W = $clog2(RCT_CUTOFF + 1);
  localparam int POS_W = $clog2(APT_WINDOW);
  localparam int CNT_W = $clog2(APT_WINDOW + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2,
    S_ALARM  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Word under test. It is rotated rather than shifted, so after 32 scan
  // cycles it again holds the original word, ready to be committed.
  logic [31:0]       r_shift;
  logic [4:0]        r_bitcnt;

  // Health-test state; it carries across word boundaries.
  logic [RUN_W-1:0]  r_run;
  logic              r_last_bit;
  logic [CNT_W-1:0]  r_apt_cnt;
  logic [POS_W-1:0]  r_apt_pos;
  logic              r_apt_ref;

  logic              r_alarm;
  logic              r_rct_fail;
  logic              r_apt_fail;
  logic [15:0]       r_drop_cnt;

  // FIFO storage and bookkeeping.
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic              w_bit;
  logic [RUN_W-1:0]  w_run_next;
  logic [CNT_W-1:0]  w_apt_cnt_next;
  logic              w_apt_ref_next;
  logic              w_rct_hit;
  logic              w_apt_hit;
  logic              w_fail;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_drop_inc;
  logic [16:0]       w_drop_sum;

  // Health-test arithmetic for the bit currently at the head of the shift register.
  always_comb begin
    w_bit = r_shift[0];

    if ((r_run == '0) || (w_bit != r_last_bit)) begin
      w_run_next = RUN_W'(1);
    end else if (r_run >= RUN_W'(RCT_CUTOFF)) begin
      w_run_next = RUN_W'(RCT_CUTOFF);
    end else begin
      w_run_next = r_run + RUN_W'(1);
    end

    if (r_apt_pos == '0) begin
      w_apt_ref_next = w_bit;
      w_apt_cnt_next = CNT_W'(1);
    end else begin
      w_apt_ref_next = r_apt_ref;
      w_apt_cnt_next = r_apt_cnt + CNT_W'(w_bit == r_apt_ref);
    end

    w_rct_hit = (w_run_next == RUN_W'(RCT_CUTOFF));
    w_apt_hit = (w_apt_cnt_next >= CNT_W'(APT_CUTOFF));
    w_fail    = (r_state == S_SCAN) && (w_rct_hit || w_apt_hit);
  end

  // FIFO handshakes and drop accounting.
  always_comb begin
    w_full     = (r_level == LVL_W'(FIFO_DEPTH));
    w_push     = (r_state == S_COMMIT) && !w_full;
    w_pop      = (r_level != '0) && out_ready;
    w_drop_inc = 2'(in_valid && ((r_state == S_SCAN) || (r_state == S_COMMIT)))
               + 2'((r_state == S_COMMIT) && w_full);
    w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_inc);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (in_valid) w_state_next = S_SCAN;
      S_SCAN: begin
        if (w_fail) begin
          w_state_next = S_ALARM;
        end else if (r_bitcnt == 5'd31) begin
          w_state_next = S_COMMIT;
        end
      end
      S_COMMIT: w_state_next = S_IDLE;
      S_ALARM:  if (alarm_clr) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Scan datapath, health-test state and sticky failure flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_run      <= '0;
      r_last_bit <= 1'b0;
      r_apt_cnt  <= '0;
      r_apt_pos  <= '0;
      r_apt_ref  <= 1'b0;
      r_alarm    <= 1'b0;
      r_rct_fail <= 1'b0;
      r_apt_fail <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift  <= in_data;
            r_bitcnt <= '0;
          end
        end
        S_SCAN: begin
          r_shift    <= {w_bit, r_shift[31:1]};
          r_bitcnt   <= r_bitcnt + 5'd1;
          r_run      <= w_run_next;
          r_last_bit <= w_bit;
          r_apt_cnt  <= w_apt_cnt_next;
          r_apt_ref  <= w_apt_ref_next;
          r_apt_pos  <= r_apt_pos + POS_W'(1);
          if (w_fail) begin
            r_alarm    <= 1'b1;
            r_rct_fail <= w_rct_hit;
            r_apt_fail <= w_apt_hit;
          end
        end
        S_ALARM: begin
          if (alarm_clr) begin
            r_alarm    <= 1'b0;
            r_rct_fail <= 1'b0;
            r_apt_fail <= 1'b0;
            r_run      <= '0;
            r_apt_pos  <= '0;
            r_apt_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating drop counter. During COMMIT it can step by two: a busy drop and a full-FIFO drop together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop_sum[16]) begin
      r_drop_cnt <= 16'hFFFF;
    end else begin
      r_drop_cnt <= w_drop_sum[15:0];
    end
  end

  // FIFO pointers and level. A health failure flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_fail) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage. A push always writes the unrotated original word.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  assign out_valid  = (r_level != '0);
  assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
  assign alarm      = r_alarm;
  assign rct_fail   = r_rct_fail;
  assign apt_fail   = r_apt_fail;
  assign busy       = (r_state != S_IDLE);
  assign fifo_level = r_level;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_trng_health_monitor.sv
// Directed bench for trng_health_monitor: table of single-word cases plus
// hand-written multi-cycle sequences (APT, FIFO full, busy drop, alarm, async reset).
module tb_trng_health_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        alarm_clr;
  logic        alarm;
  logic        rct_fail;
  logic        apt_fail;
  logic        busy;
  logic [4:0]  fifo_level;
  logic [15:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  trng_health_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alarm_clr  (alarm_clr),
    .alarm      (alarm),
    .rct_fail   (rct_fail),
    .apt_fail   (apt_fail),
    .busy       (busy),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        exp_alarm;
    logic        exp_rct;
    logic        exp_apt;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_valid, input logic [31:0] e_data,
                               input logic e_alarm, input logic e_rct, input logic e_apt,
                               input logic e_busy, input logic [4:0] e_level, input logic [15:0] e_drop);
    check({tag, ".out_valid"},  32'(out_valid),  32'(e_valid));
    check({tag, ".out_data"},   out_data,        e_data);
    check({tag, ".alarm"},      32'(alarm),      32'(e_alarm));
    check({tag, ".rct_fail"},   32'(rct_fail),   32'(e_rct));
    check({tag, ".apt_fail"},   32'(apt_fail),   32'(e_apt));
    check({tag, ".busy"},       32'(busy),       32'(e_busy));
    check({tag, ".fifo_level"}, 32'(fifo_level), 32'(e_level));
    check({tag, ".drop_cnt"},   32'(drop_cnt),   32'(e_drop));
  endtask

  // Called on a negedge; returns on the following negedge.
  task automatic send_word(input logic [31:0] w);
    $display("send word %h at %0t", w, $time);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    alarm_clr = 1'b0;
    @(negedge clk);
    check_outputs("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    alarm_clr = 1'b0;

    //                word          alarm rct   apt   valid
    vecs[0] = '{32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h80000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};

    // Single-word cases from reset: exact latency, RCT boundary at run 31/32.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      out_ready = 1'b1;
      send_word(vecs[i].word);
      repeat (32) @(negedge clk);
      check($sformatf("vec%0d.early_valid", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid,
                    vecs[i].exp_valid ? vecs[i].word : 32'h0,
                    vecs[i].exp_alarm, vecs[i].exp_rct, vecs[i].exp_apt,
                    vecs[i].exp_alarm, 5'(vecs[i].exp_valid), 16'd0);
      if (vecs[i].exp_valid) begin
        @(negedge clk);
        check($sformatf("vec%0d.level_after_pop", i), 32'(fifo_level), 32'd0);
      end
    end

    // APT: 18 words of 0x7FFFFFFF hold 558 matches; word 19 bit 30 reaches 589.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      send_word(32'h7FFFFFFF);
      repeat (39) @(negedge clk);
    end
    check_outputs("apt_pre", 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 16'd2);
    send_word(32'h7FFFFFFF);
    repeat (39) @(negedge clk);
    check_outputs("apt_fail", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 16'd2);

    // In ALARM: in_valid ignored, alarm_clr returns to IDLE, then a good word passes.
    send_word(32'h12345678);
    check_outputs("alarm_inval", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 16'd2);
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    check_outputs("alarm_clr", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd2);
    out_ready = 1'b1;
    send_word(32'hA5A5A5A5);
    repeat (33) @(negedge clk);
    check_outputs("post_clr", 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 16'd2);

    // FIFO full: 17 words with out_ready low; the 17th is dropped, then drain in order.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_word(32'hA5A5A500 | 32'(i));
      repeat (39) @(negedge clk);
    end
    check_outputs("full", 1'b1, 32'hA5A5A500, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 16'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w = 32'hA5A5A500 | 32'(i);
      check($sformatf("drain%0d", i), out_data, w);
      @(negedge clk);
    end
    check("drain.level", 32'(fifo_level), 32'd0);
    check("drain.valid", 32'(out_valid), 32'd0);

    // Busy drop: second word 5 cycles after the first is discarded.
    do_reset();
    out_ready = 1'b0;
    send_word(32'h12345678);
    repeat (4) @(negedge clk);
    send_word(32'hCAFEF00D);
    check("busy_drop.cnt", 32'(drop_cnt), 32'd1);
    repeat (40) @(negedge clk);
    check_outputs("busy_drop", 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 16'd1);
    repeat (20) @(negedge clk);
    check("busy_drop.level_hold", 32'(fifo_level), 32'd1);
    check("busy_drop.data_hold", out_data, 32'h12345678);

    // Async reset mid-SCAN: outputs clear before the next clock edge.
    send_word(32'hA5A5A5A5);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_outputs("after_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
